// File: rtl/bus_pkg.sv
// Shared bus code map, legality limits and transfer-FSM state encoding
// for the register-transfer decoder.
package bus_pkg;

   typedef enum logic [4:0] {
      R0     = 5'd0,  R1  = 5'd1,  R2  = 5'd2,  R3  = 5'd3,
      R4     = 5'd4,  R5  = 5'd5,  R6  = 5'd6,  R7  = 5'd7,
      R8     = 5'd8,  R9  = 5'd9,  R10 = 5'd10, R11 = 5'd11,
      R12    = 5'd12, R13 = 5'd13, R14 = 5'd14, R15 = 5'd15,
      HI     = 5'd16, LO  = 5'd17, ZHI = 5'd18, ZLO = 5'd19,
      PC     = 5'd20, MDR = 5'd21, INPORT = 5'd22, CSIGN = 5'd23
   } bus_code_t;

   localparam logic [4:0] MAX_SRC = CSIGN;
   localparam logic [4:0] MAX_DST = MDR;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DRIVE = 3'd1,
      LATCH = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Sources include the read-only InPort and sign-extended constant;
   // destinations stop at MDR.
   function automatic logic is_legal(input logic [4:0] src, input logic [4:0] dst);
      return (src <= MAX_SRC) && (dst <= MAX_DST);
   endfunction

endpackage

// File: rtl/onehot32_dec.sv
// Combinational 5-bit code to 32-bit one-hot decoder.
module onehot32_dec (
   input  logic [4:0]  code,
   output logic [31:0] onehot
);

   // NOTE: a full assignment every evaluation keeps always_comb free of latches.
   always_comb begin
      onehot = 32'd1 << code;
   end

endmodule

// File: rtl/bus_xfer_decoder.sv
// Sequences one bus register transfer: drive source for DRIVE_CYCLES,
// pulse the destination load enable, then report done or err.
module bus_xfer_decoder
   import bus_pkg::*;
#(
   parameter int DRIVE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  src_sel,
   input  logic [4:0]  dst_sel,
   output logic [31:0] out_sel,
   output logic [31:0] in_en,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(DRIVE_CYCLES + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic [4:0]    dst_q;
   logic [31:0]   src_oh;
   logic [31:0]   dst_oh;
   logic          accept;

   onehot32_dec u_src_dec (.code(src_sel), .onehot(src_oh));
   onehot32_dec u_dst_dec (.code(dst_q),   .onehot(dst_oh));

   assign req_ready = (state == IDLE) || (state == DONE);
   assign accept    = req_valid && req_ready;

   // NOTE: every register uses <= so all state updates see pre-edge values,
   //       and every register is cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state   <= IDLE;
         cnt     <= '0;
         dst_q   <= '0;
         out_sel <= '0;
         in_en   <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               out_sel <= '0;
               in_en   <= '0;
               if (accept && is_legal(src_sel, dst_sel)) begin
                  state   <= DRIVE;
                  cnt     <= CW'(DRIVE_CYCLES - 1);
                  dst_q   <= dst_sel;
                  out_sel <= src_oh;
               end else if (accept) begin
                  state <= ERR;
                  err   <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            DRIVE: begin
               if (cnt == '0) begin
                  state <= LATCH;
                  in_en <= dst_oh;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            LATCH: begin
               state   <= DONE;
               out_sel <= '0;
               in_en   <= '0;
               done    <= 1'b1;
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               out_sel <= '0;
               in_en   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_xfer_decoder.sv
// Directed bench for bus_xfer_decoder with DRIVE_CYCLES=1 and DRIVE_CYCLES=3 instances.
module tb_bus_xfer_decoder;

   logic        clk = 1'b0;
   logic        clr = 1'b0;

   logic        req_valid1 = 1'b0, req_ready1;
   logic [4:0]  src1 = '0, dst1 = '0;
   logic [31:0] out_sel1, in_en1;
   logic        done1, err1;

   logic        req_valid3 = 1'b0, req_ready3;
   logic [4:0]  src3 = '0, dst3 = '0;
   logic [31:0] out_sel3, in_en3;
   logic        done3, err3;

   int tests_run = 0;
   int tests_failed = 0;

   bus_xfer_decoder #(.DRIVE_CYCLES(1)) dut1 (
      .clk(clk), .clr(clr), .req_valid(req_valid1), .req_ready(req_ready1),
      .src_sel(src1), .dst_sel(dst1), .out_sel(out_sel1), .in_en(in_en1),
      .done(done1), .err(err1)
   );

   bus_xfer_decoder #(.DRIVE_CYCLES(3)) dut3 (
      .clk(clk), .clr(clr), .req_valid(req_valid3), .req_ready(req_ready3),
      .src_sel(src3), .dst_sel(dst3), .out_sel(out_sel3), .in_en(in_en3),
      .done(done3), .err(err3)
   );

   initial forever #5 clk = ~clk;

   // Observation vector: {out_sel, in_en, done, err, req_ready}
   wire [66:0] obs1 = {out_sel1, in_en1, done1, err1, req_ready1};
   wire [66:0] obs3 = {out_sel3, in_en3, done3, err3, req_ready3};

   function automatic logic [66:0] pk(input logic [31:0] o, input logic [31:0] i,
                                      input logic d, input logic e, input logic r);
      return {o, i, d, e, r};
   endfunction

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      tests_run++;
      if (obs1 !== pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         tests_failed++;
         $display("FAIL reset_dc1: got %h expected %h", obs1, pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
      end
      tests_run++;
      if (obs3 !== pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         tests_failed++;
         $display("FAIL reset_dc3: got %h expected %h", obs3, pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
      end
      step();
      step();
      clr = 1'b1;
      step();
   endtask

   // Single legal transfer on dut1, cycle-by-cycle check from N+1.
   task automatic xfer1(input string name, input logic [4:0] s, input logic [4:0] d,
                        input logic [31:0] s_oh, input logic [31:0] d_oh);
      logic [66:0] exp [4];
      exp[0] = pk(s_oh,  32'h0, 1'b0, 1'b0, 1'b0);
      exp[1] = pk(s_oh,  d_oh,  1'b0, 1'b0, 1'b0);
      exp[2] = pk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      exp[3] = pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      req_valid1 = 1'b1; src1 = s; dst1 = d;
      step();
      req_valid1 = 1'b0; src1 = 5'd31; dst1 = 5'd31;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         tests_run++;
         if (obs1 !== exp[k]) begin
            tests_failed++;
            $display("FAIL %s cyc%0d: got out_sel=%h in_en=%h done=%b err=%b rdy=%b expected %h",
                     name, k + 1, out_sel1, in_en1, done1, err1, req_ready1, exp[k]);
         end
      end
   endtask

   task automatic test_basic();
      xfer1("basic_3_to_7", 5'd3, 5'd7, 32'h0000_0008, 32'h0000_0080);
   endtask

   task automatic test_same_reg();
      xfer1("reload_5", 5'd5, 5'd5, 32'h0000_0020, 32'h0000_0020);
   endtask

   task automatic test_boundary_legal();
      xfer1("csign_to_mdr", 5'd23, 5'd21, 32'h0080_0000, 32'h0020_0000);
   endtask

   task automatic test_drive3();
      logic [66:0] exp [6];
      for (int k = 0; k < 3; k++) exp[k] = pk(32'h0010_0000, 32'h0, 1'b0, 1'b0, 1'b0);
      exp[3] = pk(32'h0010_0000, 32'h1, 1'b0, 1'b0, 1'b0);
      exp[4] = pk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
      exp[5] = pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      req_valid3 = 1'b1; src3 = 5'd20; dst3 = 5'd0;
      step();
      req_valid3 = 1'b0; src3 = 5'd9; dst3 = 5'd9;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step();
         tests_run++;
         if (obs3 !== exp[k]) begin
            tests_failed++;
            $display("FAIL drive3_pc_to_r0 cyc%0d: got out_sel=%h in_en=%h done=%b err=%b rdy=%b expected %h",
                     k + 1, out_sel3, in_en3, done3, err3, req_ready3, exp[k]);
         end
      end
   endtask

   task automatic test_err();
      logic [4:0] s_v [2];
      logic [4:0] d_v [2];
      logic [66:0] exp [3];
      s_v[0] = 5'd24; d_v[0] = 5'd0;
      s_v[1] = 5'd1;  d_v[1] = 5'd22;
      exp[0] = pk(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
      exp[1] = pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      exp[2] = pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      for (int v = 0; v < 2; v++) begin
         req_valid1 = 1'b1; src1 = s_v[v]; dst1 = d_v[v];
         step();
         req_valid1 = 1'b0;
         for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            tests_run++;
            if (obs1 !== exp[k]) begin
               tests_failed++;
               $display("FAIL err_src%0d_dst%0d cyc%0d: got out_sel=%h in_en=%h done=%b err=%b rdy=%b expected %h",
                        s_v[v], d_v[v], k + 1, out_sel1, in_en1, done1, err1, req_ready1, exp[k]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [66:0] exp [7];
      exp[0] = pk(32'h0000_0002, 32'h0,  1'b0, 1'b0, 1'b0);
      exp[1] = pk(32'h0000_0002, 32'h4,  1'b0, 1'b0, 1'b0);
      exp[2] = pk(32'h0,         32'h0,  1'b1, 1'b0, 1'b1);
      exp[3] = pk(32'h0000_0010, 32'h0,  1'b0, 1'b0, 1'b0);
      exp[4] = pk(32'h0000_0010, 32'h40, 1'b0, 1'b0, 1'b0);
      exp[5] = pk(32'h0,         32'h0,  1'b1, 1'b0, 1'b1);
      exp[6] = pk(32'h0,         32'h0,  1'b0, 1'b0, 1'b1);
      req_valid1 = 1'b1; src1 = 5'd1; dst1 = 5'd2;
      step();
      src1 = 5'd4; dst1 = 5'd6;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) step();
         if (k == 4) req_valid1 = 1'b0;
         tests_run++;
         if (obs1 !== exp[k]) begin
            tests_failed++;
            $display("FAIL back_to_back cyc%0d: got out_sel=%h in_en=%h done=%b err=%b rdy=%b expected %h",
                     k + 1, out_sel1, in_en1, done1, err1, req_ready1, exp[k]);
         end
      end
   endtask

   task automatic test_clr_in_latch();
      req_valid1 = 1'b1; src1 = 5'd2; dst1 = 5'd9;
      step();
      req_valid1 = 1'b0;
      step();
      tests_run++;
      if (obs1 !== pk(32'h4, 32'h200, 1'b0, 1'b0, 1'b0)) begin
         tests_failed++;
         $display("FAIL clr_pre_latch: got %h expected %h", obs1, pk(32'h4, 32'h200, 1'b0, 1'b0, 1'b0));
      end
      #2 clr = 1'b0;
      #1;
      tests_run++;
      if (obs1 !== pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         tests_failed++;
         $display("FAIL clr_async: got %h expected %h", obs1, pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
      end
      #2 clr = 1'b1;
      step();
      tests_run++;
      if (obs1 !== pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1)) begin
         tests_failed++;
         $display("FAIL clr_no_done: got %h expected %h", obs1, pk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
      end
      // Release lands mid-cycle, so the very next edge must accept.
      clr = 1'b0;
      #2 clr = 1'b1;
      req_valid1 = 1'b1; src1 = 5'd3; dst1 = 5'd3;
      step();
      req_valid1 = 1'b0;
      tests_run++;
      if (obs1 !== pk(32'h8, 32'h0, 1'b0, 1'b0, 1'b0)) begin
         tests_failed++;
         $display("FAIL first_accept_after_clr: got %h expected %h", obs1, pk(32'h8, 32'h0, 1'b0, 1'b0, 1'b0));
      end
      step();
      step();
      tests_run++;
      if (obs1 !== pk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1)) begin
         tests_failed++;
         $display("FAIL done_after_clr: got %h expected %h", obs1, pk(32'h0, 32'h0, 1'b1, 1'b0, 1'b1));
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_drive3();
      test_err();
      test_same_reg();
      test_boundary_legal();
      test_back_to_back();
      test_clr_in_latch();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bus_xfer_decoder.md
BUS_XFER_DECODER -- requirements
Module: bus_xfer_decoder

Interface
REQ-001 Parameter SHALL be: DRIVE_CYCLES, default 1, number of cycles the source drives the bus before the destination latches; legal range 1..15.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 clr  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  transfer request present.
REQ-005 req_ready  out  1  block can accept a request this cycle.
REQ-006 src_sel  in  5  bus source code: 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC, 21 MDR, 22 InPort, 23 C_sign_extend; 24-31 invalid.
REQ-007 dst_sel  in  5  destination code, same map; only 0-21 legal.
REQ-008 out_sel  out  32  one-hot source-select lines feeding the 32-to-5 bus encoder; bit n = code n.
REQ-009 in_en  out  32  one-hot register load enables; bit n = code n.
REQ-010 done  out  1  one-cycle pulse, transfer complete.
REQ-011 err  out  1  one-cycle pulse, request rejected.

Function
REQ-012 Handshake SHALL complete on a rising edge with req_valid=1 and req_ready=1; src_sel/dst_sel are captured on that edge and ignored at all other times.
REQ-013 FSM states SHALL be IDLE, DRIVE, LATCH, DONE, ERR.
REQ-014 req_ready SHALL be 1 in IDLE and DONE, 0 in DRIVE, LATCH, ERR.
REQ-015 Accept with src_sel>23 or dst_sel>21 SHALL go to ERR; ERR asserts err for one cycle, drives out_sel=0 and in_en=0, then returns to IDLE.
REQ-016 Accept of a legal request SHALL go to DRIVE; DRIVE lasts exactly DRIVE_CYCLES cycles with out_sel=onehot(src) and in_en=0.
REQ-017 LATCH SHALL last one cycle with out_sel=onehot(src) held and in_en=onehot(dst).
REQ-018 DONE SHALL last one cycle with done=1, out_sel=0, in_en=0; accept in DONE goes to DRIVE (or ERR), otherwise IDLE.
REQ-019 Latency: accept at edge N -> out_sel valid cycles N+1..N+DRIVE_CYCLES+1, in_en high cycle N+DRIVE_CYCLES+1, done high cycle N+DRIVE_CYCLES+2.
REQ-020 src_sel==dst_sel SHALL be a legal transfer (register reload) with normal timing.
REQ-021 At most one bit of out_sel and at most one bit of in_en SHALL be set in any cycle; in_en SHALL never be set without out_sel set.
REQ-022 All outputs except req_ready SHALL be registered; req_ready is decoded from state only.
REQ-023 DRIVE counter SHALL be $clog2(DRIVE_CYCLES+1) bits, load DRIVE_CYCLES-1 on entry, count down to 0, no wrap.

Reset
REQ-024 clr=0 SHALL immediately force state IDLE, out_sel=0, in_en=0, done=0, err=0, counter=0, req_ready=1, including mid-transfer; the aborted transfer never produces in_en or done.
REQ-025 First accept SHALL be possible on the first rising edge after clr deasserts.

Structure
REQ-026 Shared package bus_pkg SHALL hold the source/destination code constants (R0..R15, HI=16, LO=17, ZHI=18, ZLO=19, PC=20, MDR=21, INPORT=22, CSIGN=23), MAX_SRC=23, MAX_DST=21 and the FSM state enum.
REQ-027 One sub-module onehot32_dec (5-bit code in, 32-bit one-hot out, combinational) SHALL be instantiated twice, for source and destination.

Verification
REQ-028 DRIVE_CYCLES=1, src=3, dst=7 accepted at edge N -> out_sel=32'h8 cycles N+1..N+2, in_en=32'h80 cycle N+2 only, done cycle N+3.
REQ-029 DRIVE_CYCLES=3, src=20 (PC), dst=0 -> out_sel=32'h0010_0000 for 4 cycles, in_en=32'h1 in the 4th, done next cycle.
REQ-030 src=24 or dst=22 -> err pulse one cycle after accept, out_sel and in_en stay 0, no done.
REQ-031 Back-to-back: req_valid held high with two legal requests -> second accepted in DONE cycle, out_sel re-asserts the cycle after done.
REQ-032 clr pulsed low during LATCH -> in_en=0 and out_sel=0 immediately, no done, req_ready=1 after release.
REQ-033 src=dst=5 -> out_sel=in_en=32'h20 in LATCH, done asserted.
